alu_operand_skid: RTL and testbench

//   Two-entry registered skid buffer placed directly upstream of the ALU.

---
 rtl/alu_operand_skid.sv | 119 +++++++++++
 tb/tb_alu_operand_skid.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_skid.sv
// Two-entry registered skid buffer feeding the ALU. MAIN drives the outputs and
// SKID absorbs one cycle of downstream stall. in_ready comes straight from a flop.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, out_valid=0, in_ready=1
//   ST_ONE   | MAIN holds the head op, in_ready=1
//   ST_FULL  | MAIN holds the head op, SKID holds the next, in_ready=0
module alu_operand_skid #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 3,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_lhs,
  input  logic [DATA_W-1:0] in_rhs,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [TAG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_lhs,
  output logic [DATA_W-1:0] out_rhs,
  output logic [FUNC_W-1:0] out_func,
  output logic [TAG_W-1:0]  out_rd,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = 2 * DATA_W + FUNC_W + TAG_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [PAY_W-1:0] in_pay;
  logic             accept;
  logic             fire;

  assign in_pay = {in_lhs, in_rhs, in_func, in_rd};
  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_pay;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_d = in_pay;
        end else if (accept) begin
          skid_d  = in_pay;
          state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins: a same-cycle accept still handshakes but its payload is dropped.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Ready is a pure function of the next state, registered, so it never sees out_ready combinationally.
  assign in_ready_d = (state_d != ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign {out_lhs, out_rhs, out_func, out_rd} = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_skid.sv
// Bench for alu_operand_skid: directed scenarios then random traffic, all
// checked against a queue model of a two-deep in-order buffer.
module tb_alu_operand_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_lhs;
  logic [31:0] in_rhs;
  logic [2:0]  in_func;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_lhs;
  logic [31:0] out_rhs;
  logic [2:0]  out_func;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;

  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [2:0]  func;
    logic [4:0]  rd;
  } op_t;

  op_t q[$];
  int  n_pass = 0;
  int  n_total = 0;

  alu_operand_skid dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lhs    (in_lhs),
    .in_rhs    (in_rhs),
    .in_func   (in_func),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lhs   (out_lhs),
    .out_rhs   (out_rhs),
    .out_func  (out_func),
    .out_rd    (out_rd),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      check({tag, ".out_lhs"},  out_lhs,         q[0].lhs);
      check({tag, ".out_rhs"},  out_rhs,         q[0].rhs);
      check({tag, ".out_func"}, 32'(out_func),   32'(q[0].func));
      check({tag, ".out_rd"},   32'(out_rd),     32'(q[0].rd));
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input string tag, input logic v, input logic [31:0] l, input logic [31:0] r,
                      input logic [2:0] f, input logic [4:0] d, input logic ordy, input logic fl);
    op_t op;
    bit  acc, fir;
    in_valid  = v;
    in_lhs    = l;
    in_rhs    = r;
    in_func   = f;
    in_rd     = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = v && (q.size() < 2);
    fir = (q.size() > 0) && ordy;
    op.lhs = l; op.rhs = r; op.func = f; op.rd = d;
    if (fl) begin
      q.delete();
    end else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back(op);
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 32'h0, 32'h0, 3'h0, 5'h0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lhs = '0; in_rhs = '0; in_func = '0; in_rd = '0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.occupancy", 32'(occupancy), 32'd0);
    check("rst.out_lhs",   out_lhs,        32'd0);
    check("rst.out_rd",    32'(out_rd),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: back-to-back with the consumer always ready
    step("stream0", 1'b1, 32'd5, 32'd3, 3'd1, 5'd7, 1'b1, 1'b0);
    check("stream0.lhs5", out_lhs, 32'd5);
    step("stream1", 1'b1, 32'd9, 32'd4, 3'd2, 5'd8, 1'b1, 1'b0);
    check("stream1.lhs9", out_lhs, 32'd9);
    check("stream1.occ1", 32'(occupancy), 32'd1);
    idle("stream_drain", 1'b1);

    // Stall: A then B with the consumer blocked, then C held off while full
    step("stallA", 1'b1, 32'hA, 32'h1A, 3'd3, 5'd10, 1'b0, 1'b0);
    step("stallB", 1'b1, 32'hB, 32'h1B, 3'd4, 5'd11, 1'b0, 1'b0);
    check("stall.occ2", 32'(occupancy), 32'd2);
    check("stall.lhsA", out_lhs, 32'hA);
    for (int i = 0; i < 3; i++)
      step("fullC", 1'b1, 32'hC, 32'h1C, 3'd5, 5'd12, 1'b0, 1'b0);
    check("fullC.lhsA", out_lhs, 32'hA);
    step("fireA", 1'b1, 32'hC, 32'h1C, 3'd5, 5'd12, 1'b1, 1'b0);
    check("fireA.lhsB", out_lhs, 32'hB);
    step("acceptC", 1'b1, 32'hC, 32'h1C, 3'd5, 5'd12, 1'b0, 1'b0);
    idle("drainB", 1'b1);
    check("drainB.lhsC", out_lhs, 32'hC);
    idle("drainC", 1'b1);

    // Flush with an accept in ONE, and flush while FULL
    step("fl_one0", 1'b1, 32'h11, 32'h0, 3'd0, 5'd1, 1'b0, 1'b0);
    step("fl_one1", 1'b1, 32'h22, 32'h0, 3'd0, 5'd2, 1'b0, 1'b1);
    check("fl_one.valid", 32'(out_valid), 32'd0);
    step("fl_full0", 1'b1, 32'h33, 32'h0, 3'd0, 5'd3, 1'b0, 1'b0);
    step("fl_full1", 1'b1, 32'h44, 32'h0, 3'd0, 5'd4, 1'b0, 1'b0);
    step("fl_full2", 1'b1, 32'h55, 32'h0, 3'd0, 5'd5, 1'b1, 1'b1);
    check("fl_full.occ", 32'(occupancy), 32'd0);
    step("fl_after", 1'b1, 32'h66, 32'h0, 3'd0, 5'd6, 1'b0, 1'b0);
    check("fl_after.lhs", out_lhs, 32'h66);

    // Reset asserted mid-stream, between clock edges
    step("pre_rst", 1'b1, 32'h77, 32'h0, 3'd0, 5'd7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.in_ready",  32'(in_ready),  32'd1);
    check("mid_rst.occupancy", 32'(occupancy), 32'd0);
    check("mid_rst.out_lhs",   out_lhs,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst", 1'b1);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom),
           5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
